attract_screen: RTL and testbench
=================================

# attract_screen

Parametrised attract-mode animator for the tile grid. While enabled it drives a single showcase tile into an otherwise empty grid and moves or animates it once every FRAME_DIV video frames, in one of three modes. It sits between the LFSR/VGA timing logic and the grid-select mux ahead of the renderer. It supersedes the fixed 4x4 random-hop start screen and adds enable/exit handshaking and selectable animation modes.

## Interface
- GRID_SIZE, 4, cells per side; NUM_CELLS = GRID_SIZE*GRID_SIZE, IDX_BITS = $clog2(NUM_CELLS)
- CELL_BITS, 4, bits per cell (log2 tile exponent)
- TILE_VALUE, 11, exponent shown by the tile (11 = 2048); must be 1..2^CELL_BITS-1
- FRAME_DIV, 30, vsync edges between updates; >= 1; counter width $clog2(FRAME_DIV+1)

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- vsync_rising_edge  in  1  one-cycle pulse per frame
- lfsr_out  in  IDX_BITS  free-running random index, changes every cycle
- enable  in  1  level; high requests animation, low requests exit
- mode  in  2  0 = random hop, 1 = raster sweep, 2 = pulse in place, 3 = treated as 0
- grid  out  NUM_CELLS*CELL_BITS  cell i at bits [i*CELL_BITS +: CELL_BITS]
- tile_pos  out  IDX_BITS  current tile index
- active  out  1  high in WAIT and PLACE
- done  out  1  one-cycle pulse on the EXIT->IDLE transition

## Operation
- States: IDLE, PLACE, WAIT, EXIT.
- IDLE: grid = 0, tile_pos = 0, counter = 0. enable=1 -> PLACE next cycle.
- PLACE: latch mode, then compute the new tile.
  - Hop: accept lfsr_out only if < NUM_CELLS and != tile_pos. Otherwise stay in PLACE and retry next cycle. The first placement after IDLE accepts any lfsr_out < NUM_CELLS.
  - Sweep: tile_pos+1, wraps NUM_CELLS-1 -> 0. The first placement after IDLE is index 0.
  - Pulse: position unchanged. Value steps 1,2,...,TILE_VALUE, then wraps to 1. The first placement after IDLE shows TILE_VALUE at index 0.
  - On acceptance, write the whole grid: all cells 0 except tile_pos. Clear counter. Go to WAIT.
- WAIT: counter increments on each vsync_rising_edge. When counter reaches FRAME_DIV -> PLACE.
- enable=0 in PLACE or WAIT -> EXIT next cycle. This takes priority over all other transitions.
- EXIT: grid cleared to 0, counter cleared. done=1 for one cycle, then IDLE.
- Hop and sweep always show TILE_VALUE. Pulse value register width is CELL_BITS.

## Timing
- All outputs are registered. Reset values: grid 0, tile_pos 0, active 0, done 0, state IDLE.
- First tile appears 2 cycles after enable rises in IDLE (IDLE->PLACE, PLACE->WAIT with grid write), except in hop mode when lfsr_out must be retried.
- Update period: FRAME_DIV vsync edges plus 1 PLACE cycle plus hop retries.
- vsync_rising_edge arriving in PLACE, EXIT or IDLE is ignored (not counted).
- vsync_rising_edge coincident with enable falling: exit wins, no update.
- mode changes are visible only at the next PLACE. The grid never shows a partial update.
- enable re-raised during EXIT: EXIT still completes with done, then IDLE, then PLACE.
- Reset mid-operation: all state and outputs return to reset values on the next edge.

## Structure
- Package attract_pkg holds the mode constants (MODE_HOP, MODE_SWEEP, MODE_PULSE) and the state enum.
- Sub-module frame_timer: counts vsync edges up to FRAME_DIV. Inputs: clear and count-enable. Output: an expiry flag.
- The FSM, position/value registers and grid builder live in attract_screen.

## Test plan
- Reset, then enable=1, mode=1, FRAME_DIV=2 -> tile 11 at index 0. After 2 vsyncs, at index 1. After 16 updates it wraps back to index 0 with GRID_SIZE=4.
- Mode=0, force lfsr_out = current index for 5 cycles, then 7 -> stays in PLACE for 5 cycles, then tile_pos=7 and only cell 7 is nonzero.
- GRID_SIZE=3, mode=0, lfsr_out=12 then 4 -> 12 is rejected, tile placed at 4, grid width 36 bits.
- Mode=2, TILE_VALUE=3 -> cell 0 shows 3,1,2,3,1 on successive updates.
- enable dropped in WAIT together with vsync -> next cycle EXIT, grid=0, done=1 for exactly one cycle, then active=0.
- rst_n low for one cycle mid-WAIT -> grid=0, tile_pos=0, state IDLE; with enable still high, a tile appears 2 cycles after release.

Source files
------------

// File: rtl/attract_pkg.sv
// -----------------------------------------------------------------------------
// attract_pkg
// Shared definitions for the attract-mode animator: animation mode encodings
// and the controller state enumeration.
// -----------------------------------------------------------------------------
package attract_pkg;

    // Animation mode encodings (mode value 3 falls back to random hop)
    localparam logic [1:0] MODE_HOP   = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;
    localparam logic [1:0] MODE_PULSE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        WAIT  = 2'd2,
        EXIT  = 2'd3
    } state_e;

endpackage

// File: rtl/attract_screen_if.sv
// -----------------------------------------------------------------------------
// attract_screen_if
// Bundles the attract animator's frame/random/control inputs and its grid
// outputs.
//   master : drives vsync_rising_edge, lfsr_out, enable, mode; observes outputs
//   slave  : the animator itself; receives the inputs, drives grid, tile_pos,
//            active, done
// -----------------------------------------------------------------------------
interface attract_screen_if #(
    parameter int GRID_SIZE = 4,
    parameter int CELL_BITS = 4
);
    localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
    localparam int IDX_BITS  = $clog2(NUM_CELLS);

    logic                           vsync_rising_edge;
    logic [IDX_BITS-1:0]            lfsr_out;
    logic                           enable;
    logic [1:0]                     mode;
    logic [NUM_CELLS*CELL_BITS-1:0] grid;
    logic [IDX_BITS-1:0]            tile_pos;
    logic                           active;
    logic                           done;

    modport master (
        output vsync_rising_edge, lfsr_out, enable, mode,
        input  grid, tile_pos, active, done
    );

    modport slave (
        input  vsync_rising_edge, lfsr_out, enable, mode,
        output grid, tile_pos, active, done
    );

endinterface

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Counts vsync edges up to FRAME_DIV and then holds, flagging expiry.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   clear_i    : zero the count (has priority over counting)
//   count_en_i : count one frame edge
//   expired_o  : count has reached FRAME_DIV
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int FRAME_DIV = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);
    localparam int              CNT_W = $clog2(FRAME_DIV + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FRAME_DIV);

    logic [CNT_W-1:0] count_q, count_d;

    // Saturate at the limit so extra edges never wrap the counter
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/attract_screen.sv
// -----------------------------------------------------------------------------
// attract_screen
// Attract-mode animator: while enabled, shows a single tile in an otherwise
// empty grid and moves/animates it every FRAME_DIV frames (random hop, raster
// sweep or in-place pulse). Dropping enable clears the grid and pulses done.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of attract_screen_if
//           in : vsync_rising_edge, lfsr_out, enable, mode
//           out: grid (cell i at [i*CELL_BITS +: CELL_BITS]), tile_pos,
//                active (PLACE/WAIT), done (one cycle while in EXIT)
// All outputs are registered.
// -----------------------------------------------------------------------------
module attract_screen
    import attract_pkg::*;
#(
    parameter int GRID_SIZE  = 4,
    parameter int CELL_BITS  = 4,
    parameter int TILE_VALUE = 11,
    parameter int FRAME_DIV  = 30
) (
    input logic             clk,
    input logic             rst_n,
    attract_screen_if.slave bus
);
    localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
    localparam int IDX_BITS  = $clog2(NUM_CELLS);
    localparam int GRID_W    = NUM_CELLS * CELL_BITS;

    localparam logic [CELL_BITS-1:0] TILE_V   = CELL_BITS'(TILE_VALUE);
    localparam logic [CELL_BITS-1:0] ONE_V    = CELL_BITS'(1);
    localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(NUM_CELLS - 1);

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic                 first_q, first_d;   // next placement is the first since IDLE
    logic [IDX_BITS-1:0]  pos_q, pos_d;
    logic [CELL_BITS-1:0] val_q, val_d;
    logic [GRID_W-1:0]    grid_q, grid_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;

    logic                 cand_ok;
    logic [IDX_BITS-1:0]  cand_pos;
    logic [CELL_BITS-1:0] cand_val;
    logic                 timer_clear;
    logic                 timer_count;
    logic                 timer_expired;

    // Whole-grid image with exactly one nonzero cell
    function automatic logic [GRID_W-1:0] build_grid(input logic [IDX_BITS-1:0]  pos,
                                                     input logic [CELL_BITS-1:0] val);
        logic [GRID_W-1:0] g;
        g = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (pos == IDX_BITS'(i)) begin
                g[i*CELL_BITS +: CELL_BITS] = val;
            end
        end
        return g;
    endfunction

    // The counter only runs while waiting; every other state holds it at zero,
    // so stray vsync pulses outside WAIT are never counted.
    assign timer_clear = (state_q != WAIT);
    assign timer_count = (state_q == WAIT) && bus.vsync_rising_edge;

    frame_timer #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (timer_clear),
        .count_en_i (timer_count),
        .expired_o  (timer_expired)
    );

    // Candidate placement for the latched mode
    always_comb begin
        cand_ok  = 1'b0;
        cand_pos = pos_q;
        cand_val = TILE_V;
        case (mode_q)
            MODE_SWEEP: begin
                cand_ok  = 1'b1;
                cand_pos = (first_q || (pos_q == LAST_IDX)) ? '0 : pos_q + 1'b1;
            end
            MODE_PULSE: begin
                cand_ok  = 1'b1;
                cand_val = (first_q || (val_q == TILE_V)) ?
                           (first_q ? TILE_V : ONE_V) : val_q + 1'b1;
            end
            default: begin
                // Random hop: out-of-range or same-cell values are retried
                cand_pos = bus.lfsr_out;
                cand_ok  = (int'(bus.lfsr_out) < NUM_CELLS) &&
                           (first_q || (bus.lfsr_out != pos_q));
            end
        endcase
    end

    // Next-state and registered-output logic; enable low beats everything else
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        first_d = first_q;
        pos_d   = pos_q;
        val_d   = val_q;
        grid_d  = grid_q;

        case (state_q)
            IDLE: begin
                first_d = 1'b1;
                if (bus.enable) begin
                    state_d = PLACE;
                end
            end
            PLACE: begin
                if (!bus.enable) begin
                    state_d = EXIT;
                end else if (cand_ok) begin
                    pos_d   = cand_pos;
                    val_d   = cand_val;
                    grid_d  = build_grid(cand_pos, cand_val);
                    first_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.enable) begin
                    state_d = EXIT;
                end else if (timer_expired) begin
                    state_d = PLACE;
                end
            end
            EXIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Mode is sampled only when a placement round begins
        if ((state_d == PLACE) && (state_q != PLACE)) begin
            mode_d = bus.mode;
        end
        if ((state_d == EXIT) || (state_d == IDLE)) begin
            grid_d = '0;
        end
        if (state_d == IDLE) begin
            pos_d = '0;
        end

        active_d = (state_d == PLACE) || (state_d == WAIT);
        done_d   = (state_d == EXIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_HOP;
            first_q  <= 1'b1;
            pos_q    <= '0;
            val_q    <= TILE_V;
            grid_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            pos_q    <= pos_d;
            val_q    <= val_d;
            grid_q   <= grid_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.grid     = grid_q;
    assign bus.tile_pos = pos_q;
    assign bus.active   = active_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_attract_screen.sv
// -----------------------------------------------------------------------------
// tb_attract_screen
// Directed bench for attract_screen. Instance A: 4x4 grid, TILE_VALUE 11,
// FRAME_DIV 2. Instance B: 3x3 grid, TILE_VALUE 3, FRAME_DIV 1.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_attract_screen;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    attract_screen_if #(.GRID_SIZE(4), .CELL_BITS(4)) ia ();
    attract_screen_if #(.GRID_SIZE(3), .CELL_BITS(4)) ib ();

    attract_screen #(
        .GRID_SIZE(4), .CELL_BITS(4), .TILE_VALUE(11), .FRAME_DIV(2)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    attract_screen #(
        .GRID_SIZE(3), .CELL_BITS(4), .TILE_VALUE(3), .FRAME_DIV(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] one_tile(input int pos, input int val);
        return 64'(val) << (pos * 4);
    endfunction

    task automatic vsync_a();
        ia.vsync_rising_edge = 1'b1;
        tick(1);
        ia.vsync_rising_edge = 1'b0;
        tick(1);
    endtask

    // FRAME_DIV=2 vsyncs, one cycle to leave WAIT, one PLACE cycle
    task automatic upd_a();
        vsync_a();
        vsync_a();
        tick(1);
    endtask

    task automatic upd_b();
        ib.vsync_rising_edge = 1'b1;
        tick(1);
        ib.vsync_rising_edge = 1'b0;
        tick(2);
    endtask

    initial begin
        int pulse_exp[4];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ia.vsync_rising_edge = 1'b0; ia.lfsr_out = '0; ia.enable = 1'b0; ia.mode = 2'd0;
        ib.vsync_rising_edge = 1'b0; ib.lfsr_out = '0; ib.enable = 1'b0; ib.mode = 2'd0;
        tick(3);

        // Reset state
        check("rst_grid",   ia.grid, 64'h0);
        check("rst_pos",    ia.tile_pos, 64'h0);
        check("rst_active", ia.active, 64'h0);
        check("rst_done",   ia.done, 64'h0);
        check("rst_grid_b", ib.grid, 64'h0);

        // Sweep mode
        rst_n = 1'b1; ia.mode = 2'd1; ia.enable = 1'b1;
        tick(1);
        check("sweep_place_active", ia.active, 64'h1);
        check("sweep_place_grid",   ia.grid, 64'h0);
        tick(1);
        check("sweep_first_grid", ia.grid, one_tile(0, 11));
        check("sweep_first_pos",  ia.tile_pos, 64'h0);
        upd_a();
        check("sweep_1_pos",  ia.tile_pos, 64'h1);
        check("sweep_1_grid", ia.grid, one_tile(1, 11));
        for (int i = 2; i < 16; i++) begin
            upd_a();
            check("sweep_n_pos", ia.tile_pos, 64'(i));
        end
        upd_a();
        check("sweep_wrap_pos",  ia.tile_pos, 64'h0);
        check("sweep_wrap_grid", ia.grid, one_tile(0, 11));

        // Enable drops together with vsync in WAIT
        ia.enable = 1'b0; ia.vsync_rising_edge = 1'b1;
        tick(1);
        ia.vsync_rising_edge = 1'b0;
        check("exit_done",   ia.done, 64'h1);
        check("exit_grid",   ia.grid, 64'h0);
        check("exit_active", ia.active, 64'h0);
        tick(1);
        check("idle_done",   ia.done, 64'h0);
        check("idle_active", ia.active, 64'h0);
        check("idle_pos",    ia.tile_pos, 64'h0);

        // Random hop with repeated same-cell lfsr values
        ia.mode = 2'd0; ia.lfsr_out = 4'd3; ia.enable = 1'b1;
        tick(2);
        check("hop_first_pos",  ia.tile_pos, 64'h3);
        check("hop_first_grid", ia.grid, one_tile(3, 11));
        vsync_a();
        vsync_a();
        tick(5);
        check("hop_retry_active", ia.active, 64'h1);
        check("hop_retry_pos",    ia.tile_pos, 64'h3);
        check("hop_retry_grid",   ia.grid, one_tile(3, 11));
        ia.lfsr_out = 4'd7;
        tick(1);
        check("hop_accept_pos",  ia.tile_pos, 64'h7);
        check("hop_accept_grid", ia.grid, one_tile(7, 11));

        // Reset mid-WAIT with enable still high
        rst_n = 1'b0;
        tick(1);
        check("midrst_grid",   ia.grid, 64'h0);
        check("midrst_pos",    ia.tile_pos, 64'h0);
        check("midrst_active", ia.active, 64'h0);
        rst_n = 1'b1; ia.lfsr_out = 4'd5;
        tick(1);
        check("midrst_place_grid", ia.grid, 64'h0);
        tick(1);
        check("midrst_tile_pos",  ia.tile_pos, 64'h5);
        check("midrst_tile_grid", ia.grid, one_tile(5, 11));

        // Enable re-raised during EXIT still runs EXIT -> IDLE -> PLACE
        ia.enable = 1'b0;
        tick(1);
        check("reexit_done", ia.done, 64'h1);
        ia.enable = 1'b1;
        tick(1);
        check("reexit_idle_active", ia.active, 64'h0);
        check("reexit_idle_done",   ia.done, 64'h0);
        tick(1);
        check("reexit_place_active", ia.active, 64'h1);

        // 3x3 grid: out-of-range lfsr rejected
        ib.mode = 2'd0; ib.lfsr_out = 4'd12; ib.enable = 1'b1;
        tick(2);
        check("b_reject_active", ib.active, 64'h1);
        check("b_reject_grid",   ib.grid, 64'h0);
        ib.lfsr_out = 4'd4;
        tick(1);
        check("b_hop_pos",  ib.tile_pos, 64'h4);
        check("b_hop_grid", ib.grid, one_tile(4, 3));
        ib.enable = 1'b0;
        tick(1);
        check("b_exit_done", ib.done, 64'h1);
        tick(1);

        // Pulse mode with TILE_VALUE 3
        ib.mode = 2'd2; ib.enable = 1'b1;
        tick(2);
        check("b_pulse_first", ib.grid, one_tile(0, 3));
        pulse_exp[0] = 1; pulse_exp[1] = 2; pulse_exp[2] = 3; pulse_exp[3] = 1;
        for (int i = 0; i < 4; i++) begin
            upd_b();
            check("b_pulse_step", ib.grid, one_tile(0, pulse_exp[i]));
        end
        check("b_pulse_pos", ib.tile_pos, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
